// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes and
// the ALU / immediate select codes used by the datapath.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from the FSM's ALUOp class and the instruction's
// funct fields; purely combinational.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // sub only for R-type; addi with imm[10]=1 must still add
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style controller: state sequencing, Moore output decode,
// immediate format decode and branch-qualified PC write.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, compute branch target
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write load data to register file
// MEMWRITE | write store data to memory
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BEQ      | compare, redirect PC when equal
// JAL      | PC <= target, compute link address
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    state_t     state;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTER;
                        OP_ITYPE:     state <= EXECUTEI;
                        OP_BEQ:       state <= BEQ;
                        OP_JAL:       state <= JAL;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                JAL:      state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        aluop     = ALUOP_ADD;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state)
            FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~is_supported(op);
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Side-effecting strobes are held off while reset is applied
    assign PCWrite   = (pc_update | (branch & Zero)) & ~rst;
    assign IRWrite   = ir_write & ~rst;
    assign MemWrite  = mem_write & ~rst;
    assign RegWrite  = reg_write & ~rst;
    assign IllegalOp = illegal & ~rst;

    always_comb begin
        case (op)
            OP_LW, OP_ITYPE: ImmSrc = IMM_I;
            OP_SW:           ImmSrc = IMM_S;
            OP_BEQ:          ImmSrc = IMM_B;
            OP_JAL:          ImmSrc = IMM_J;
            default:         ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed vector table, reset corner
// sequences and randomized instruction streams against a per-cycle model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctrl_t;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL, C_ILL} cls_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         lat;
        int         cyc;
        ctrl_t      exp;
    } vec_t;

    vec_t vq[$];

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ctrl_t cw(logic pcw, logic adr, logic mw, logic ir, logic rw,
                                 logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                 logic [1:0] imm, logic [2:0] alu, logic ill);
        return {pcw, adr, mw, ir, rw, rs, a, b, imm, alu, ill};
    endfunction

    function automatic ctrl_t actual();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%05h expected=%05h", name, $time, got, exp);
        end
    endtask

    function automatic int latency(cls_t c);
        case (c)
            C_LW:    return 5;
            C_BEQ:   return 3;
            C_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] arith(logic [2:0] f3, logic is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word for cycle 'cyc' (1-based) of one instruction.
    function automatic ctrl_t model(cls_t c, logic [6:0] o, logic [2:0] f3, logic f7,
                                    logic z, int cyc);
        ctrl_t w = '0;
        w.immsrc = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        if (cyc == 1) begin
            w.irwrite = 1'b1; w.pcwrite = 1'b1; w.alusrcb = 2'b10; w.resultsrc = 2'b10;
        end else if (cyc == 2) begin
            w.alusrca = 2'b01; w.alusrcb = 2'b01; w.illegal = (c == C_ILL);
        end else begin
            case (c)
                C_LW, C_SW: begin
                    if (cyc == 3) begin w.alusrca = 2'b10; w.alusrcb = 2'b01; end
                    else if (cyc == 4) begin
                        w.adrsrc = 1'b1;
                        w.memwrite = (c == C_SW);
                    end else begin
                        w.resultsrc = 2'b01; w.regwrite = 1'b1;
                    end
                end
                C_R, C_I: begin
                    if (cyc == 3) begin
                        w.alusrca = 2'b10;
                        w.alusrcb = (c == C_I) ? 2'b01 : 2'b00;
                        w.alucontrol = arith(f3, o[5] & f7);
                    end else w.regwrite = 1'b1;
                end
                C_BEQ: begin
                    w.alusrca = 2'b10; w.alucontrol = 3'b001; w.pcwrite = z;
                end
                C_JAL: begin
                    if (cyc == 3) begin
                        w.alusrca = 2'b01; w.alusrcb = 2'b10; w.pcwrite = 1'b1;
                    end else w.regwrite = 1'b1;
                end
                default: ;
            endcase
        end
        return w;
    endfunction

    // Leaves the bench at the start of the first FETCH cycle after reset.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_gate", {12'd0, PCWrite, IRWrite, MemWrite, RegWrite, IllegalOp}, 17'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(string n, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                           int lat, int cyc, ctrl_t e);
        vec_t v;
        v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z;
        v.lat = lat; v.cyc = cyc; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic run_vec(vec_t v);
        do_reset();
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.zero;
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            if (c == v.cyc) check(v.name, actual(), v.exp);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({v.name, "_next_fetch"}, {14'd0, IRWrite, ResultSrc}, {14'd0, 3'b110});
        @(posedge clk); #1;
    endtask

    initial begin
        cls_t       c;
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;

        add_vec("lw_fetch",    LW, 3'b010, 0, 0, 5, 1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        add_vec("lw_memadr",   LW, 3'b010, 0, 0, 5, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        add_vec("lw_memread",  LW, 3'b010, 0, 0, 5, 4, cw(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        add_vec("lw_memwb",    LW, 3'b010, 0, 0, 5, 5, cw(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
        add_vec("sw_decode",   SW, 3'b010, 0, 0, 4, 2, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        add_vec("sw_memwrite", SW, 3'b010, 0, 0, 4, 4, cw(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        add_vec("beq_taken",   BQ, 3'b000, 0, 1, 3, 3, cw(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        add_vec("beq_not",     BQ, 3'b000, 0, 0, 3, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        add_vec("r_sub",       RT, 3'b000, 1, 0, 4, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
        add_vec("r_add",       RT, 3'b000, 0, 0, 4, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0));
        add_vec("r_and",       RT, 3'b111, 0, 0, 4, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0));
        add_vec("r_or_wb",     RT, 3'b110, 0, 0, 4, 4, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        add_vec("i_addi_f7",   IT, 3'b000, 1, 0, 4, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        add_vec("i_slti",      IT, 3'b010, 0, 0, 4, 3, cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0));
        add_vec("jal_exec",    JL, 3'b000, 0, 0, 4, 3, cw(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
        add_vec("jal_wb",      JL, 3'b000, 0, 0, 4, 4, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,0));
        add_vec("illegal_dec", 7'b0000000, 3'b000, 0, 0, 2, 2, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,1));
        add_vec("illegal_fet", 7'b0000000, 3'b000, 0, 0, 2, 1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

        foreach (vq[i]) run_vec(vq[i]);

        // Reset asserted in MEMWRITE: store suppressed, restart at FETCH.
        do_reset();
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_memwrite", actual(), cw(0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("fetch_after_rst", actual(), cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        @(posedge clk); #1;

        // Reset asserted in FETCH with a branch pending Zero: all strobes held off.
        do_reset();
        op = BQ; Zero = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_fetch", actual(), cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized back-to-back instruction stream.
        for (int n = 0; n < 300; n++) begin
            c  = cls_t'($urandom_range(0, 6));
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            case (c)
                C_LW:  o = LW;
                C_SW:  o = SW;
                C_R:   o = RT;
                C_I:   o = IT;
                C_BEQ: o = BQ;
                C_JAL: o = JL;
                default: begin
                    o = 7'($urandom_range(0, 127));
                    while (o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL)
                        o = 7'($urandom_range(0, 127));
                end
            endcase
            op = o; funct3 = f3; funct7b5 = f7;
            for (int cy = 1; cy <= latency(c); cy++) begin
                Zero = 1'($urandom_range(0, 1));
                @(negedge clk);
                check($sformatf("rand_%0d_op%07b_cyc%0d", n, o, cy), actual(),
                      model(c, o, f3, f7, Zero, cy));
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 op  in  7  instruction opcode field, bits [6:0].
REQ-005 funct3  in  3  instruction bits [14:12].
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag (Z).
REQ-008 PCWrite  out  1  PC register enable.
REQ-009 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 MemWrite, IRWrite, RegWrite  out  1 each  write enables.
REQ-011 ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 ALUSrcA  out  2  A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-013 ALUSrcB  out  2  B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
REQ-014 ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 ALUControl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-016 IllegalOp  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-017 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; the state register is the only storage.
REQ-018 Transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR on op 0000011 (lw) or 0100011 (sw).
- DECODE -> EXECUTER on 0110011; -> EXECUTEI on 0010011; -> BEQ on 1100011; -> JAL on 1101111.
- DECODE -> FETCH on any other opcode.
REQ-019 More transitions:
- MEMADR -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD -> MEMWB -> FETCH; MEMWRITE -> FETCH.
- EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH; BEQ -> FETCH.
REQ-020 Outputs SHALL be Moore-decoded from state (except PCWrite, ImmSrc and ALUControl); any output not listed for a state SHALL be 0:
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-021 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally.
REQ-022 ImmSrc SHALL be decoded combinationally from op: lw/addi-class = 00, sw = 01, beq = 10, jal = 11, all others = 00.
REQ-023 ALUControl decode:
- ALUOp 00 -> 000; ALUOp 01 -> 001.
- ALUOp 10 with funct3 000 -> 001 if op[5] AND funct7b5, else 000.
- ALUOp 10 with funct3 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-024 IllegalOp SHALL be 1 only in DECODE with an unsupported opcode; that instruction SHALL have no register, memory or PC side effects.
REQ-025 Instruction latencies in cycles SHALL be: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
REQ-026 op, funct3 and funct7b5 are held stable by the instruction register after FETCH; the controller SHALL NOT latch them.

Reset
REQ-027 When rst=1 at a rising edge, the state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-028 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp SHALL be forced to 0.
REQ-029 In the first cycle after rst deasserts, outputs SHALL be the FETCH values.

Structure
REQ-030 Shared package SHALL hold: state encodings (4-bit), opcode constants, ALUControl codes, ALUOp codes, ImmSrc codes.
REQ-031 The ALU decode (REQ-023) SHALL be a sub-module named alu_decoder; the FSM and the ImmSrc decode stay in multicycle_controller.

Verification
REQ-032 lw (op=0000011) after reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5, with ResultSrc=01.
REQ-033 beq (op=1100011), Zero=1 -> PCWrite=1 in cycle 3 with ALUControl=001; repeated with Zero=0 -> PCWrite=0 in cycle 3; both return to FETCH in cycle 4.
REQ-034 R-type with funct3=000: funct7b5=1 -> ALUControl=001 in EXECUTER; funct7b5=0 -> 000; with funct3=111 -> 010.
REQ-035 op=0000000 -> IllegalOp=1 in cycle 2, FETCH in cycle 3, and no write enable asserted except IRWrite in FETCH.
REQ-036 rst=1 asserted during MEMWRITE -> MemWrite=0 that cycle, state=FETCH on the next edge, IRWrite=1 after release.
